// File: rtl/dp_share_arbiter.sv
// rtl/dp_share_arbiter.sv - round-robin owner arbiter for the shared LED-effect datapath
// Two masters compete; a hold limit preempts an unlocked owner while the other waits.
module dp_share_arbiter #(
  parameter int IMM_W    = 32,
  parameter int AW       = 3,
  parameter int MAX_HOLD = 64,
  parameter int HW       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  logic [AW-1:0]    m0_ra1,
  input  logic [AW-1:0]    m1_ra1,
  input  logic [AW-1:0]    m0_ra2,
  input  logic [AW-1:0]    m1_ra2,
  input  logic [AW-1:0]    m0_wa,
  input  logic [AW-1:0]    m1_wa,
  input  logic [IMM_W-1:0] m0_imm,
  input  logic [IMM_W-1:0] m1_imm,
  input  logic [1:0]       m0_wd_sel,
  input  logic [1:0]       m1_wd_sel,
  input  logic [2:0]       m0_alu_op,
  input  logic [2:0]       m1_alu_op,
  input  logic [4:0]       m0_ctl,
  input  logic [4:0]       m1_ctl,
  output logic [1:0]       gnt,
  output logic [AW-1:0]    ra1,
  output logic [AW-1:0]    ra2,
  output logic [AW-1:0]    wa,
  output logic [IMM_W-1:0] imm,
  output logic [1:0]       wd_sel,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic             ld_we,
  output logic             c_reset,
  output logic             c_limit_we,
  output logic             c_enable,
  output logic             preempt
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state, state_nx;
  logic          last_owner, last_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          preempt_nx;
  logic          own;
  logic          own_req, oth_req, own_lock;

  assign own      = (state == OWN1);
  assign own_req  = req[own];
  assign oth_req  = req[~own];
  assign own_lock = lock[own];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      preempt    <= 1'b0;
    end else begin
      state      <= state_nx;
      last_owner <= last_nx;
      hold_cnt   <= hold_nx;
      preempt    <= preempt_nx;
    end
  end

  // hold_nx defaults to zero so any state change or stall condition clears it
  always_comb begin
    state_nx   = state;
    last_nx    = last_owner;
    hold_nx    = '0;
    preempt_nx = 1'b0;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) state_nx = last_owner ? OWN0 : OWN1;
        else if (req[0])      state_nx = OWN0;
        else if (req[1])      state_nx = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          last_nx  = own;
          state_nx = oth_req ? (own ? OWN0 : OWN1) : IDLE;
        end else if (oth_req && !own_lock) begin
          if (hold_cnt == HW'(MAX_HOLD - 1)) begin
            last_nx    = own;
            state_nx   = own ? OWN0 : OWN1;
            preempt_nx = 1'b1;
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign gnt = {state == OWN1, state == OWN0};

  always_comb begin
    ra1        = '0;
    ra2        = '0;
    wa         = '0;
    imm        = '0;
    wd_sel     = '0;
    alu_op     = '0;
    {rf_we, ld_we, c_reset, c_limit_we, c_enable} = 5'b0;
    if (gnt[0]) begin
      ra1 = m0_ra1; ra2 = m0_ra2; wa = m0_wa; imm = m0_imm;
      wd_sel = m0_wd_sel; alu_op = m0_alu_op;
      {rf_we, ld_we, c_reset, c_limit_we, c_enable} = m0_ctl;
    end else if (gnt[1]) begin
      ra1 = m1_ra1; ra2 = m1_ra2; wa = m1_wa; imm = m1_imm;
      wd_sel = m1_wd_sel; alu_op = m1_alu_op;
      {rf_we, ld_we, c_reset, c_limit_we, c_enable} = m1_ctl;
    end
  end

endmodule

// File: tb/tb_dp_share_arbiter.sv
// tb/tb_dp_share_arbiter.sv - directed self-checking bench for dp_share_arbiter
module tb_dp_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0, lock = '0;
  logic [2:0]  m0_ra1 = '0, m1_ra1 = '0, m0_ra2 = '0, m1_ra2 = '0, m0_wa = '0, m1_wa = '0;
  logic [31:0] m0_imm = '0, m1_imm = '0;
  logic [1:0]  m0_wd_sel = '0, m1_wd_sel = '0;
  logic [2:0]  m0_alu_op = '0, m1_alu_op = '0;
  logic [4:0]  m0_ctl = '0, m1_ctl = '0;
  logic [1:0]  gnt;
  logic [2:0]  ra1, ra2, wa;
  logic [31:0] imm;
  logic [1:0]  wd_sel;
  logic [2:0]  alu_op;
  logic        rf_we, ld_we, c_reset, c_limit_we, c_enable, preempt;

  int total = 0;
  int bad = 0;

  dp_share_arbiter #(.IMM_W(32), .AW(3), .MAX_HOLD(64), .HW(7)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .m0_ra1(m0_ra1), .m1_ra1(m1_ra1), .m0_ra2(m0_ra2), .m1_ra2(m1_ra2),
    .m0_wa(m0_wa), .m1_wa(m1_wa), .m0_imm(m0_imm), .m1_imm(m1_imm),
    .m0_wd_sel(m0_wd_sel), .m1_wd_sel(m1_wd_sel),
    .m0_alu_op(m0_alu_op), .m1_alu_op(m1_alu_op),
    .m0_ctl(m0_ctl), .m1_ctl(m1_ctl),
    .gnt(gnt), .ra1(ra1), .ra2(ra2), .wa(wa), .imm(imm), .wd_sel(wd_sel),
    .alu_op(alu_op), .rf_we(rf_we), .ld_we(ld_we), .c_reset(c_reset),
    .c_limit_we(c_limit_we), .c_enable(c_enable), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lock = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    m0_ctl = 5'b11111; m1_ctl = 5'b11111; m0_imm = 32'h1234_5678; m1_wa = 3'd6;
    do_reset();
    total++;
    if (gnt !== 2'b00 || preempt !== 1'b0) begin
      bad++; $display("FAIL reset_gnt: gnt=%b preempt=%b want 00 0", gnt, preempt);
    end
    total++;
    if ({rf_we, ld_we, c_reset, c_limit_we, c_enable} !== 5'b0 || imm !== 32'h0 || wa !== 3'd0) begin
      bad++; $display("FAIL reset_outputs: ctl=%b imm=%h wa=%0d want zeros",
                      {rf_we, ld_we, c_reset, c_limit_we, c_enable}, imm, wa);
    end
  endtask

  task automatic test_grant_route();
    do_reset();
    req = 2'b01;
    m0_ctl = 5'b10000; m0_wa = 3'd3; m0_ra1 = 3'd1; m0_ra2 = 3'd2;
    m0_imm = 32'hDEAD_BEEF; m0_wd_sel = 2'd2; m0_alu_op = 3'd5;
    m1_ctl = 5'b11111; m1_wa = 3'd5; m1_imm = 32'hFFFF_0000;
    total++;
    if (rf_we !== 1'b0 || gnt !== 2'b00) begin
      bad++; $display("FAIL pre_grant_discard: rf_we=%b gnt=%b want 0 00", rf_we, gnt);
    end
    tick();
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL grant0: gnt=%b want 01", gnt); end
    total++;
    if (rf_we !== 1'b1 || wa !== 3'd3) begin
      bad++; $display("FAIL route_we: rf_we=%b wa=%0d want 1 3", rf_we, wa);
    end
    total++;
    if ({ld_we, c_reset, c_limit_we, c_enable} !== 4'b0) begin
      bad++; $display("FAIL nonowner_gate: got %b want 0000", {ld_we, c_reset, c_limit_we, c_enable});
    end
    total++;
    if (imm !== 32'hDEAD_BEEF || ra1 !== 3'd1 || ra2 !== 3'd2 || wd_sel !== 2'd2 || alu_op !== 3'd5) begin
      bad++; $display("FAIL route_bus: imm=%h ra1=%0d ra2=%0d wd=%0d op=%0d want deadbeef 1 2 2 5",
                      imm, ra1, ra2, wd_sel, alu_op);
    end
    m0_ctl = 5'b00001;
    #1;
    total++;
    if (c_enable !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL zero_latency: c_enable=%b rf_we=%b want 1 0", c_enable, rf_we);
    end
    m0_ctl = '0; m1_ctl = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 2'b11; tick();
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL tie_first: gnt=%b want 01", gnt); end
    req = 2'b10; tick();
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL handover: gnt=%b want 10", gnt); end
    req = 2'b00; tick();
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL release_idle: gnt=%b want 00", gnt); end
    req = 2'b11; tick();
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL tie_after_m1: gnt=%b want 01", gnt); end
  endtask

  // Owner 0 holds; req[1] rises just after an edge; expect grant flip 64 edges later.
  task automatic run_preempt(input string name);
    int early = 0;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (gnt !== 2'b01 || preempt !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL %s_early: early_cycles=%0d want 0", name, early); end
    tick();
    total++;
    if (gnt !== 2'b10 || preempt !== 1'b1) begin
      bad++; $display("FAIL %s_fire: gnt=%b preempt=%b want 10 1", name, gnt, preempt);
    end
    tick();
    total++;
    if (gnt !== 2'b10 || preempt !== 1'b0) begin
      bad++; $display("FAIL %s_pulse: gnt=%b preempt=%b want 10 0", name, gnt, preempt);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 2'b01; tick();
    req = 2'b11;
    run_preempt("preempt");
  endtask

  task automatic test_lock();
    int lost = 0;
    do_reset();
    req = 2'b01; tick();
    lock = 2'b01; req = 2'b11;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gnt !== 2'b01 || preempt !== 1'b0) lost++;
    end
    total++;
    if (lost != 0) begin bad++; $display("FAIL lock_hold: lost_cycles=%0d want 0", lost); end
    lock = 2'b00;
    run_preempt("unlock");
  endtask

  task automatic test_nonowner_lock();
    do_reset();
    req = 2'b01; tick();
    lock = 2'b10; req = 2'b11;
    run_preempt("foreign_lock");
    lock = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10; m1_ctl = 5'b01000; tick();
    total++;
    if (gnt !== 2'b10 || ld_we !== 1'b1) begin
      bad++; $display("FAIL own1_ld: gnt=%b ld_we=%b want 10 1", gnt, ld_we);
    end
    req = 2'b11;
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (gnt !== 2'b00 || ld_we !== 1'b0) begin
      bad++; $display("FAIL mid_reset: gnt=%b ld_we=%b want 00 0", gnt, ld_we);
    end
    total++;
    if (dut.hold_cnt !== 7'd0) begin
      bad++; $display("FAIL mid_reset_hold: hold_cnt=%0d want 0", dut.hold_cnt);
    end
    tick();
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL post_reset_tie: gnt=%b want 01", gnt); end
    m1_ctl = '0;
  endtask

  initial begin
    test_reset();
    test_grant_route();
    test_back_to_back();
    test_preempt();
    test_lock();
    test_nonowner_lock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
